wb_bus_arbiter: RTL and testbench



---
 rtl/wb_pkg.sv | 33 +++
 rtl/wb_bus_arbiter_if.sv | 42 ++++
 rtl/wb_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_wb_bus_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types, default widths and the round-robin pick used by the Wishbone arbiter.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

  localparam int DEF_ADR_W = 24;
  localparam int DEF_DAT_W = 32;
  localparam int MAX_M     = 8;

  // First set bit of req searching upward from (last+1) mod n, wrapping; one-hot result.
  function automatic logic [MAX_M-1:0] rr_pick(input logic [MAX_M-1:0] req,
                                               input logic [2:0]       last,
                                               input int               n);
    logic [MAX_M-1:0] sel;
    logic             found;
    logic [2:0]       idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_M; k++) begin
      idx = 3'((int'(last) + k) % n);
      if (!found && (k <= n) && req[idx]) begin
        sel[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/wb_bus_arbiter_if.sv
// Bundle of the master-side and slave-side Wishbone signals around the arbiter.
interface wb_bus_arbiter_if
  import wb_pkg::*;
#(
  parameter int NUM_M = 2,
  parameter int ADR_W = DEF_ADR_W,
  parameter int DAT_W = DEF_DAT_W
) ();

  logic [NUM_M-1:0]       i_m_cyc;
  logic [NUM_M-1:0]       i_m_stb;
  logic [NUM_M-1:0]       i_m_we;
  logic [NUM_M*ADR_W-1:0] i_m_adr;
  logic [NUM_M*DAT_W-1:0] i_m_dat;
  logic [NUM_M-1:0]       o_m_ack;
  logic [NUM_M-1:0]       o_m_err;
  logic [DAT_W-1:0]       o_m_dat;
  logic                   o_s_cyc;
  logic                   o_s_stb;
  logic                   o_s_we;
  logic [ADR_W-1:0]       o_s_adr;
  logic [DAT_W-1:0]       o_s_dat;
  logic                   i_s_ack;
  logic [DAT_W-1:0]       i_s_dat;
  logic [NUM_M-1:0]       o_grant;
  logic                   o_busy;

  // Environment side: the bus masters plus the shared slave.
  modport master (
    output i_m_cyc, i_m_stb, i_m_we, i_m_adr, i_m_dat, i_s_ack, i_s_dat,
    input  o_m_ack, o_m_err, o_m_dat, o_s_cyc, o_s_stb, o_s_we, o_s_adr, o_s_dat,
    input  o_grant, o_busy
  );

  // Arbiter side.
  modport slave (
    input  i_m_cyc, i_m_stb, i_m_we, i_m_adr, i_m_dat, i_s_ack, i_s_dat,
    output o_m_ack, o_m_err, o_m_dat, o_s_cyc, o_s_stb, o_s_we, o_s_adr, o_s_dat,
    output o_grant, o_busy
  );

endinterface

// File: rtl/wb_bus_arbiter.sv
// Round-robin Wishbone classic arbiter: NUM_M masters share one slave bus, with a
// no-ack timeout that aborts the cycle and reports an error to the owner.
module wb_bus_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_M   = 2,
  parameter int ADR_W   = DEF_ADR_W,
  parameter int DAT_W   = DEF_DAT_W,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  wb_bus_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_M);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t       state_q, state_d;
  logic [NUM_M-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             own_cyc, own_stb, own_we;
  logic [ADR_W-1:0] own_adr;
  logic [DAT_W-1:0] own_dat;
  logic [MAX_M-1:0] req_w;
  logic             timeout_hit;
  logic             live, in_busy, s_cyc;

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (grant_q[i]) begin
        own_cyc = bus.i_m_cyc[i];
        own_stb = bus.i_m_stb[i];
        own_we  = bus.i_m_we[i];
        own_adr = bus.i_m_adr[i*ADR_W +: ADR_W];
        own_dat = bus.i_m_dat[i*DAT_W +: DAT_W];
      end
    end
  end

  always_comb begin
    req_w = '0;
    for (int i = 0; i < NUM_M; i++) req_w[i] = bus.i_m_cyc[i];
  end

  // A simultaneous ack always beats the timeout.
  assign timeout_hit = (state_q == BUSY) && own_cyc && own_stb && !bus.i_s_ack &&
                       (cnt_q == CNT_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_M - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.i_m_cyc) begin
          state_d = BUSY;
          grant_d = NUM_M'(rr_pick(req_w, 3'(last_q), NUM_M));
          cnt_d   = '0;
          for (int i = 0; i < NUM_M; i++) begin
            if (grant_d[i]) last_d = IDX_W'(i);
          end
        end
      end
      BUSY: begin
        if (!own_cyc) begin
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
        end else if (timeout_hit) begin
          state_d = ABORT;
          cnt_d   = '0;
        end else if (own_stb && !bus.i_s_ack) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
        end
      end
      ABORT: begin
        if (!own_cyc) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are forced quiet while rst is high so masters never see a stale grant.
  assign live    = !rst;
  assign in_busy = live && (state_q == BUSY);
  assign s_cyc   = in_busy && own_cyc && !timeout_hit;

  assign bus.o_s_cyc = s_cyc;
  assign bus.o_s_stb = s_cyc && own_stb;
  assign bus.o_s_we  = s_cyc && own_we;
  assign bus.o_s_adr = s_cyc ? own_adr : '0;
  assign bus.o_s_dat = s_cyc ? own_dat : '0;
  assign bus.o_m_dat = (live && (state_q != IDLE)) ? bus.i_s_dat : '0;
  assign bus.o_grant = live ? grant_q : '0;
  assign bus.o_busy  = live && (state_q != IDLE);

  always_comb begin
    bus.o_m_ack = '0;
    bus.o_m_err = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (grant_q[i]) begin
        bus.o_m_ack[i] = s_cyc && bus.i_s_ack;
        bus.o_m_err[i] = in_busy && timeout_hit;
      end
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: per-cycle vector table plus timeout, ack-race and reset sequences.
module tb_wb_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_bus_arbiter_if #(.NUM_M(2), .ADR_W(24), .DAT_W(32)) bus ();

  wb_bus_arbiter #(.NUM_M(2), .ADR_W(24), .DAT_W(32), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    bit          r;
    logic [1:0]  cyc, stb, we;
    bit          ack;
    logic [31:0] sdat;
    logic [1:0]  e_grant;
    bit          e_scyc, e_sstb;
    logic [1:0]  e_ack, e_err;
    bit          e_busy;
  } vec_t;

  typedef struct {
    string       name;
    logic [1:0]  grant;
    bit          scyc, sstb, swe;
    logic [23:0] adr;
    logic [31:0] dat;
    logic [1:0]  ack, err;
    bit          busy;
    logic [31:0] mdat;
  } exp_t;

  logic [23:0] m_adr [2];
  logic [31:0] m_dat [2];
  exp_t        sb [$];
  vec_t        tbl [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic vec_t mk(string name, bit r, logic [1:0] cyc, logic [1:0] stb,
                              logic [1:0] we, bit ack, logic [31:0] sdat,
                              logic [1:0] g, bit scyc, bit sstb, logic [1:0] mack,
                              logic [1:0] merr, bit busy);
    vec_t v;
    v.name = name; v.r = r; v.cyc = cyc; v.stb = stb; v.we = we; v.ack = ack;
    v.sdat = sdat; v.e_grant = g; v.e_scyc = scyc; v.e_sstb = sstb;
    v.e_ack = mack; v.e_err = merr; v.e_busy = busy;
    return v;
  endfunction

  task automatic check(string name, string what, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, expected %h", name, what, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    exp_t e;
    int   o;
    @(posedge clk);
    #1;
    rst         = v.r;
    bus.i_m_cyc = v.cyc;
    bus.i_m_stb = v.stb;
    bus.i_m_we  = v.we;
    bus.i_s_ack = v.ack;
    bus.i_s_dat = v.sdat;
    o       = v.e_grant[1] ? 1 : 0;
    e.name  = v.name;
    e.grant = v.e_grant;
    e.scyc  = v.e_scyc;
    e.sstb  = v.e_sstb;
    e.swe   = v.e_scyc ? v.we[o] : 1'b0;
    e.adr   = v.e_scyc ? m_adr[o] : 24'h0;
    e.dat   = v.e_scyc ? m_dat[o] : 32'h0;
    e.ack   = v.e_ack;
    e.err   = v.e_err;
    e.busy  = v.e_busy;
    e.mdat  = v.e_busy ? v.sdat : 32'h0;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check(e.name, "grant", 32'(bus.o_grant), 32'(e.grant));
    check(e.name, "s_cyc", 32'(bus.o_s_cyc), 32'(e.scyc));
    check(e.name, "s_stb", 32'(bus.o_s_stb), 32'(e.sstb));
    check(e.name, "s_we",  32'(bus.o_s_we),  32'(e.swe));
    check(e.name, "s_adr", 32'(bus.o_s_adr), 32'(e.adr));
    check(e.name, "s_dat", bus.o_s_dat, e.dat);
    check(e.name, "m_ack", 32'(bus.o_m_ack), 32'(e.ack));
    check(e.name, "m_err", 32'(bus.o_m_err), 32'(e.err));
    check(e.name, "busy",  32'(bus.o_busy),  32'(e.busy));
    check(e.name, "m_dat", bus.o_m_dat, e.mdat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_adr[0] = 24'h000010; m_adr[1] = 24'h000020;
    m_dat[0] = 32'hA5A5A5A5; m_dat[1] = 32'h12345678;
    bus.i_m_adr = {24'h000020, 24'h000010};
    bus.i_m_dat = {32'h12345678, 32'hA5A5A5A5};
    bus.i_m_cyc = '0; bus.i_m_stb = '0; bus.i_m_we = '0;
    bus.i_s_ack = 1'b0; bus.i_s_dat = '0;

    //               name           r cyc stb we ack sdat          g scyc sstb ack err busy
    tbl.push_back(mk("rst0",        1, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("rst1",        1, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("m0_req",      0, 1, 1, 1, 0, 32'h0,         0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("m0_wait1",    0, 1, 1, 1, 0, 32'h0,         1, 1, 1, 0, 0, 1));
    tbl.push_back(mk("m0_wait2",    0, 1, 1, 1, 0, 32'h0,         1, 1, 1, 0, 0, 1));
    tbl.push_back(mk("m0_ack",      0, 1, 1, 1, 1, 32'h0,         1, 1, 1, 1, 0, 1));
    tbl.push_back(mk("m0_drop",     0, 0, 0, 0, 0, 32'h0,         1, 0, 0, 0, 0, 1));
    tbl.push_back(mk("idle_a",      0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("rst2",        1, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("both_req",    0, 3, 3, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("m0_first",    0, 3, 3, 0, 1, 32'h11111111,  1, 1, 1, 1, 0, 1));
    tbl.push_back(mk("m0_done",     0, 2, 2, 0, 0, 32'h0,         1, 0, 0, 0, 0, 1));
    tbl.push_back(mk("gap_m1",      0, 2, 2, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("m1_read",     0, 2, 2, 0, 1, 32'hDEADBEEF,  2, 1, 1, 2, 0, 1));
    tbl.push_back(mk("m1_done",     0, 1, 1, 0, 0, 32'h0,         2, 0, 0, 0, 0, 1));
    tbl.push_back(mk("gap_m0",      0, 1, 1, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("m0_again",    0, 1, 1, 0, 1, 32'h0,         1, 1, 1, 1, 0, 1));
    tbl.push_back(mk("alt_drop0",   0, 2, 2, 0, 0, 32'h0,         1, 0, 0, 0, 0, 1));
    tbl.push_back(mk("alt_gap1",    0, 3, 3, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("alt_m1",      0, 3, 3, 0, 1, 32'h0,         2, 1, 1, 2, 0, 1));
    tbl.push_back(mk("alt_drop1",   0, 1, 1, 0, 0, 32'h0,         2, 0, 0, 0, 0, 1));
    tbl.push_back(mk("alt_gap2",    0, 3, 3, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("alt_m0",      0, 3, 3, 0, 1, 32'h0,         1, 1, 1, 1, 0, 1));
    tbl.push_back(mk("alt_drop2",   0, 2, 2, 0, 0, 32'h0,         1, 0, 0, 0, 0, 1));
    tbl.push_back(mk("alt_gap3",    0, 2, 2, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("alt_m1b",     0, 2, 2, 0, 1, 32'h0,         2, 1, 1, 2, 0, 1));
    tbl.push_back(mk("alt_end",     0, 0, 0, 0, 0, 32'h0,         2, 0, 0, 0, 0, 1));
    tbl.push_back(mk("idle_b",      0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) apply(tbl[i]);

    // Slave never acks: error on the 9th strobe cycle, late ack in ABORT is swallowed.
    apply(mk("to_req",      0, 1, 1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++)
      apply(mk("to_stb",    0, 1, 1, 0, 0, 32'h0, 1, 1, 1, 0, 0, 1));
    apply(mk("to_err",      0, 1, 1, 0, 0, 32'h0, 1, 0, 0, 0, 1, 1));
    apply(mk("abort_hold",  0, 1, 1, 0, 0, 32'h0, 1, 0, 0, 0, 0, 1));
    apply(mk("late_ack",    0, 1, 1, 0, 1, 32'h0, 1, 0, 0, 0, 0, 1));
    apply(mk("abort_drop",  0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 1));
    apply(mk("abort_idle",  0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0));

    // Ack arriving exactly at the timeout limit wins over the abort.
    apply(mk("race_req",    0, 2, 2, 2, 0, 32'h0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++)
      apply(mk("race_stb",  0, 2, 2, 2, 0, 32'h0, 2, 1, 1, 0, 0, 1));
    apply(mk("race_ack",    0, 2, 2, 2, 1, 32'h0, 2, 1, 1, 2, 0, 1));
    apply(mk("race_drop",   0, 0, 0, 0, 0, 32'h0, 2, 0, 0, 0, 0, 1));
    apply(mk("race_idle",   0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0));

    // Reset in the middle of a cycle restores the pointer so master 0 wins again.
    apply(mk("mr_req",      0, 3, 3, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0));
    apply(mk("mr_busy",     0, 3, 3, 0, 0, 32'h0, 1, 1, 1, 0, 0, 1));
    apply(mk("mr_rst",      1, 3, 3, 0, 1, 32'h0, 0, 0, 0, 0, 0, 0));
    apply(mk("mr_after",    0, 3, 3, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0));
    apply(mk("mr_regrant",  0, 3, 3, 0, 1, 32'h0, 1, 1, 1, 1, 0, 1));
    apply(mk("mr_drop",     0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 1));
    apply(mk("mr_idle",     0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
